dma_device_arbiter: RTL
=======================

# dma_device_arbiter

Shares the single DMA controller channel between up to NUM_DEV DMA-capable peripherals. It arbitrates round-robin among the devices' request lines and latches the winner's transfer descriptor (start address, word count, direction). It then forwards the winner's handshake signals to the controller and routes the controller's acknowledge, end flag and read data back to that device only. It sits between the peripheral bus devices and the DMA controller, replacing the point-to-point device/controller wiring.

## Interface
Parameters:
- NUM_DEV, 4, number of requesting devices (2..8)
- TIMEOUT_CYC, 1024, cycles without dma_ack before a forced release (used only with DMA_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- dev_rqst  in  NUM_DEV  per-device DMA request (level)
- dev_rd_wr  in  NUM_DEV  per-device direction, 1 = read, 0 = write
- dev_start_address  in  16*NUM_DEV  packed start addresses; device i at [16i+15:16i]
- dev_num_words  in  16*NUM_DEV  packed word counts
- dev_wdata  in  16*NUM_DEV  packed write data from each device
- dev_hs_ack  in  NUM_DEV  per-device dev_ack (2-phase handshake)
- dev_dma_ack  out  NUM_DEV  dma_ack routed to the granted device
- dev_dma_end  out  NUM_DEV  dma_end_flag routed to the granted device
- dev_rdata  out  16  controller read data, broadcast
- dma_rqst  out  1  request to controller
- dma_rd_wr  out  1  latched direction
- dma_start_address  out  16  latched start address
- dma_num_words  out  16  latched word count
- dma_dev_out  out  16  granted device's write data
- dma_dev_ack  out  1  granted device's handshake ack
- dma_ack  in  1  controller acknowledge
- dma_end_flag  in  1  controller end-of-transfer
- dma_dev_in  in  16  controller read data
- grant  out  NUM_DEV  one-hot current owner, 0 when idle
- busy  out  1  state != IDLE
- timeout_flag  out  1  sticky forced-release indicator

## Operation
- FSM states are IDLE, LOAD, BUSY and DONE.
- IDLE: when any dev_rqst bit is set, select the first requester at or after rr_ptr (wrapping modulo NUM_DEV). Register grant, the winner's start address, word count and rd_wr, then go to LOAD.
- LOAD: one cycle with descriptor outputs stable and dma_rqst=0. Go to BUSY.
- BUSY: dma_rqst=1. Exit to DONE when dma_end_flag=1 or the granted dev_rqst=0 (abort).
- DONE: dma_rqst=0. Hold grant until the granted dev_rqst=0 and dma_end_flag=0. Then set rr_ptr = winner+1 (wraps), clear grant and go to IDLE.
- Routing is combinational from the grant register:
  - dev_dma_ack = {NUM_DEV{dma_ack}} & grant
  - dev_dma_end = {NUM_DEV{dma_end_flag}} & grant
  - dma_dev_out and dma_dev_ack are muxed from the granted index, and are 0 and 1 respectively when grant=0
  - dev_rdata = dma_dev_in
- Descriptor inputs are sampled only in IDLE. Later changes have no effect until the next grant.
- Requests raised during LOAD/BUSY/DONE wait. They are served in rotation order, and no device is served twice while another waits.

## Timing
- Reset values: grant=0, busy=0, dma_rqst=0, dma_rd_wr=0, dma_start_address=0, dma_num_words=0, timeout_flag=0, rr_ptr=0, state=IDLE. Routed outputs are 0; dma_dev_ack=1.
- Request latency: dev_rqst sampled high in cycle n, grant valid in n+1, dma_rqst high in n+2.
- Release: dma_end_flag high in cycle m makes dma_rqst low in m+1. The next grant comes no earlier than one cycle after the DONE exit.
- Simultaneous end flag and abort in BUSY are treated as a normal end.
- Reset mid-transfer: returns to IDLE immediately with all outputs at reset values and the pointer at 0.
- A dev_rqst pulse shorter than one cycle while IDLE may be missed; devices hold requests level.

## Configuration
- DMA_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on grant and on every dma_ack, and increments in BUSY.
  - When it reaches TIMEOUT_CYC-1, the arbiter forces DONE with dma_rqst=0 and sets timeout_flag.
  - In DONE it waits only for dma_end_flag=0 and ignores the stuck dev_rqst. The timed-out device is skipped until its dev_rqst drops once.
  - timeout_flag clears on the next grant.
- DMA_ARB_TIMEOUT_EN undefined: no counter, timeout_flag tied to 0, and BUSY exits only as above.

## Structure
- Shared package dma_arb_pkg holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, BUSY=2'd2, DONE=2'd3)
  - the 16-bit address/word width constant
  - the default TIMEOUT_CYC
- One sub-module, dma_rr_picker: combinational round-robin selector taking request vector and pointer, producing a one-hot winner and its index.

## Test plan
- Single request: dev_rqst=4'b0010 with addr 16'h0200, 8 words, read. Expect grant=4'b0010 at +1, dma_start_address=16'h0200, dma_num_words=8, dma_rqst at +2; dev_dma_ack[1] mirrors dma_ack and the other bits stay 0.
- Round-robin: all four devices request continuously with end flags after 3 acks each. Expect grant order 0,1,2,3,0, with dma_rqst low for at least 2 cycles between owners.
- Abort: the granted device drops dev_rqst mid-BUSY. Expect dma_rqst=0 next cycle, then IDLE, and the pointer advanced.
- Write data path: device 2 is granted with write, dev_wdata[2]=16'hBEEF and dev_hs_ack[2] toggling. Expect dma_dev_out=16'hBEEF and dma_dev_ack following dev_hs_ack[2].
- Reset in BUSY: assert reset during a transfer. Expect all outputs at reset values immediately, and a new request granted starting from device 0.
- With DMA_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: no dma_ack for 16 cycles. Expect timeout_flag=1, dma_rqst=0, and a stuck requester skipped on the next arbitration.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA device arbiter: FSM state encoding,
// data/address width and the default forced-release timeout.
package dma_arb_pkg;

  localparam int DATA_W          = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dma_device_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request bit at or after ptr,
// wrapping modulo NUM_DEV. Returns the one-hot winner and its index.
module dma_rr_picker
  import dma_arb_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int IDX_W   = $clog2(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_DEV-1:0] winner,
  output logic [IDX_W-1:0]   win_idx,
  output logic               found
);

  logic [IDX_W-1:0] j;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      j = IDX_W'((int'(ptr) + k) % NUM_DEV);
      if (!found && req[j]) begin
        found     = 1'b1;
        winner[j] = 1'b1;
        win_idx   = j;
      end
    end
  end

endmodule

// File: rtl/dma_device_arbiter.sv
// Round-robin owner of the single DMA controller channel among NUM_DEV devices.
// Optional forced release on a silent controller: define DMA_ARB_TIMEOUT_EN.
module dma_device_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_DEV     = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_DEV-1:0]        dev_rqst,
  input  logic [NUM_DEV-1:0]        dev_rd_wr,
  input  logic [DATA_W*NUM_DEV-1:0] dev_start_address,
  input  logic [DATA_W*NUM_DEV-1:0] dev_num_words,
  input  logic [DATA_W*NUM_DEV-1:0] dev_wdata,
  input  logic [NUM_DEV-1:0]        dev_hs_ack,
  output logic [NUM_DEV-1:0]        dev_dma_ack,
  output logic [NUM_DEV-1:0]        dev_dma_end,
  output logic [DATA_W-1:0]         dev_rdata,
  output logic                      dma_rqst,
  output logic                      dma_rd_wr,
  output logic [DATA_W-1:0]         dma_start_address,
  output logic [DATA_W-1:0]         dma_num_words,
  output logic [DATA_W-1:0]         dma_dev_out,
  output logic                      dma_dev_ack,
  input  logic                      dma_ack,
  input  logic                      dma_end_flag,
  input  logic [DATA_W-1:0]         dma_dev_in,
  output logic [NUM_DEV-1:0]        grant,
  output logic                      busy,
  output logic                      timeout_flag,
  output arb_state_t                state
);

  localparam int IDX_W = $clog2(NUM_DEV);

  if (NUM_DEV < 2 || NUM_DEV > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
    $error("dma_device_arbiter: unsupported NUM_DEV or TIMEOUT_CYC");
  end

  arb_state_t          state_q;
  logic [NUM_DEV-1:0]  grant_q;
  logic [IDX_W-1:0]    win_idx_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic                rqst_q;
  logic                rd_wr_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   words_q;
  logic                tflag_q;

  logic [DATA_W-1:0]   addr_arr  [NUM_DEV];
  logic [DATA_W-1:0]   words_arr [NUM_DEV];
  logic [DATA_W-1:0]   wdata_arr [NUM_DEV];

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_unpack
    assign addr_arr[i]  = dev_start_address[i*DATA_W +: DATA_W];
    assign words_arr[i] = dev_num_words[i*DATA_W +: DATA_W];
    assign wdata_arr[i] = dev_wdata[i*DATA_W +: DATA_W];
  end

  logic [NUM_DEV-1:0]  skip;
  logic [NUM_DEV-1:0]  pick_winner;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                granted_rqst;
  logic                timeout_hit;
  logic                done_ignore;
  logic                done_ok;
  logic [IDX_W-1:0]    next_ptr;

  dma_rr_picker #(.NUM_DEV(NUM_DEV), .IDX_W(IDX_W)) u_picker (
    .req     (dev_rqst & ~skip),
    .ptr     (rr_ptr_q),
    .winner  (pick_winner),
    .win_idx (pick_idx),
    .found   (pick_found)
  );

  assign granted_rqst = |(dev_rqst & grant_q);
  // A timed-out owner may hold its request stuck, so DONE only waits for end flag.
  assign done_ok      = !dma_end_flag && (done_ignore || !granted_rqst);
  assign next_ptr     = (win_idx_q == IDX_W'(NUM_DEV - 1)) ? '0 : win_idx_q + 1'b1;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0]        to_cnt_q;
  logic [NUM_DEV-1:0] skip_q;
  logic               timed_out_q;

  // End flag and abort take precedence over a coincident timeout.
  assign timeout_hit = (state_q == BUSY) && (to_cnt_q == TO_LAST) && !dma_ack &&
                       !dma_end_flag && granted_rqst;
  assign skip        = skip_q;
  assign done_ignore = timed_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q    <= '0;
      skip_q      <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if ((state_q == IDLE && pick_found) || dma_ack) to_cnt_q <= '0;
      else if (state_q == BUSY)                       to_cnt_q <= to_cnt_q + 16'd1;
      skip_q <= (skip_q & dev_rqst) | (timeout_hit ? grant_q : '0);
      if (timeout_hit)          timed_out_q <= 1'b1;
      else if (state_q == IDLE) timed_out_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign skip        = '0;
  assign done_ignore = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      win_idx_q <= '0;
      rr_ptr_q  <= '0;
      rqst_q    <= 1'b0;
      rd_wr_q   <= 1'b0;
      addr_q    <= '0;
      words_q   <= '0;
      tflag_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pick_found) begin
          grant_q   <= pick_winner;
          win_idx_q <= pick_idx;
          rd_wr_q   <= dev_rd_wr[pick_idx];
          addr_q    <= addr_arr[pick_idx];
          words_q   <= words_arr[pick_idx];
          tflag_q   <= 1'b0;
          state_q   <= LOAD;
        end
        LOAD: begin
          rqst_q  <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: if (dma_end_flag || !granted_rqst || timeout_hit) begin
          rqst_q  <= 1'b0;
          state_q <= DONE;
          if (timeout_hit) tflag_q <= 1'b1;
        end
        DONE: if (done_ok) begin
          rr_ptr_q <= next_ptr;
          grant_q  <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dev_dma_ack       = {NUM_DEV{dma_ack}} & grant_q;
  assign dev_dma_end       = {NUM_DEV{dma_end_flag}} & grant_q;
  assign dev_rdata         = dma_dev_in;
  assign dma_dev_out       = (|grant_q) ? wdata_arr[win_idx_q] : '0;
  assign dma_dev_ack       = (|grant_q) ? dev_hs_ack[win_idx_q] : 1'b1;
  assign dma_rqst          = rqst_q;
  assign dma_rd_wr         = rd_wr_q;
  assign dma_start_address = addr_q;
  assign dma_num_words     = words_q;
  assign grant             = grant_q;
  assign busy              = (state_q != IDLE);
  assign timeout_flag      = tflag_q;
  assign state             = state_q;

endmodule
